forward_sb: RTL and testbench
=============================

Name: forward_sb

Overview:
- Parametrised successor of the pipeline forwarding/hazard unit.
- Keeps its own DEPTH-stage shift register of in-flight register writes: destination, data and data-ready state.
- Resolves NUM_RD read ports against that shift register, youngest match first.
- Raises a load-use stall while a matched load's data has not yet returned; supports a variable-latency data memory in place of a fixed one-stage load bubble.

Parameters:
- NUM_RD, 3: number of source-operand read ports (ra/rb/rt = 3).
- DW, 32: data width.
- AW, 5: register address width.
- DEPTH, 3: in-flight stages tracked, issue through register-file write; legal 2..8.
- ZERO_REG, 1: 1 = address 0 is hard-wired zero, never tracked or matched.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hold  in  1  pipeline frozen this cycle; no shift, no issue capture
- iss_valid  in  1  instruction leaving execute this cycle
- iss_we  in  1  instruction writes a register
- iss_addr  in  AW  destination register
- iss_is_load  in  1  data comes from memory; iss_data ignored
- iss_data  in  DW  ALU or immediate result
- ld_valid  in  1  load data returning this cycle
- ld_data  in  DW  returned load data
- rd_en  in  NUM_RD  read port active
- rd_addr  in  NUM_RD*AW  packed source addresses, port 0 in LSBs
- rd_rf_data  in  NUM_RD*DW  register-file read data
- fwd_data  out  NUM_RD*DW  forwarded operands
- fwd_hit  out  NUM_RD  port served from the shift register
- stall  out  1  load-use hazard; upstream must not issue
- ld_err  out  1  sticky: ld_valid with no pending load
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset, synchronous: all entries invalid; stall_cnt=0; ld_err=0. Comb outputs follow: stall=0, fwd_hit=0, fwd_data=rd_rf_data.
- Entry format: {vld, addr, rdy, data}.
- Shift, each cycle with hold=0:
  - stage k moves to k+1;
  - stage DEPTH-1 is discarded; the register file wrote it that cycle.
- Capture: stage 0 is loaded from iss_* when iss_valid & iss_we & !(ZERO_REG & iss_addr==0). Otherwise stage 0 becomes invalid.
  - Non-load: rdy=1, data=iss_data.
  - Load: rdy=0.
- hold=1: no shift, no capture; the issue is ignored. Load fill still occurs.
- Load fill: on ld_valid, the oldest (highest stage) valid entry with rdy=0 takes rdy=1, data=ld_data.
  - Fill and shift may occur in the same cycle; the filled entry lands in its shifted position.
  - If no entry has rdy=0: ld_err sets and stays set until rst.
  - A load still not ready when discarded at DEPTH-1 is lost and also sets ld_err.
- Read resolve, combinational, per port p:
  - Scan stages 0..DEPTH-1; the first valid entry with addr==rd_addr[p] wins (youngest).
  - Match and rdy=1: fwd_data=entry data, fwd_hit=1.
  - Match and rdy=0: fwd_hit=1, fwd_data=don't-care, hazard_p=1.
  - No match: fwd_data=rd_rf_data, fwd_hit=0.
  - Address 0 with ZERO_REG=1 never matches.
  - Port with rd_en=0: hazard_p=0.
- stall = OR of hazard_p. It is asserted the same cycle as the read and is not registered.
  - stall has no effect on shifting; upstream drives iss_valid=0 (bubble).
- stall_cnt: +1 on each cycle with stall=1 and hold=0; saturates at all-ones.
- Simultaneous:
  - A read matching stage 0 sees the entry captured in the previous cycle, never the current iss_*.
  - A load fill lands in the same cycle it arrives, so a hazard on that entry clears combinationally that cycle; stall reads 0 once ld_valid fills the matched entry.

Decomposition:
- Shared package (def_muxs.v style defines): entry field widths, the ZERO_REG address constant, and the resolve-mux select codes (ORI, STAGE_n) for debug observation.
- One natural sub-module: forward_sb_port, the per-read-port priority matcher (DEPTH entries in, data/hit/hazard out), instantiated NUM_RD times in a generate loop.
- The shift register, fill logic and counters stay in the top module.

Test Plan:
- ALU back-to-back: issue r3=0x11 (non-load), next cycle read port0 r3, rf=0 → fwd_hit[0]=1, data 0x11, stall=0.
- Youngest wins: issue r5=0xA, then r5=0xB, then read r5 → 0xB. After DEPTH further cycles with no issue → data = rd_rf_data, hit=0.
- Load-use: issue load r7, read port1 r7 → stall=1. Hold no ld_valid for 2 cycles → stall stays 1, stall_cnt=2. Then ld_valid ld_data=0xDEAD → stall=0 same cycle, fwd_data=0xDEAD.
- Hold: issue r2=0x5, assert hold 3 cycles, read r2 every cycle → data 0x5 throughout; entry stays at stage 0; the issue presented during hold is not captured.
- Zero register and error: issue r0=0xFF, read r0 → hit=0. ld_valid with no pending load → ld_err=1, cleared only by rst.
- Reset mid-operation: two pending loads, rst pulse → stall=0, all hit=0, stall_cnt=0, ld_err=0 next cycle.

Source files
------------

// File: rtl/forward_sb_pkg.sv
// Shared defaults, the hard-wired zero register address and the resolve-mux
// select codes used by the forwarding scoreboard.
package forward_sb_pkg;

  localparam int unsigned DEF_NUM_RD   = 3;
  localparam int unsigned DEF_DW       = 32;
  localparam int unsigned DEF_AW       = 5;
  localparam int unsigned DEF_DEPTH    = 3;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam bit          DEF_ZERO_REG = 1'b1;

  localparam int unsigned ZERO_ADDR = 0;

  // ORI selects the register file; STAGEn selects shift-register stage n.
  typedef enum logic [3:0] {
    SEL_ORI    = 4'd0,
    SEL_STAGE0 = 4'd1,
    SEL_STAGE1 = 4'd2,
    SEL_STAGE2 = 4'd3,
    SEL_STAGE3 = 4'd4,
    SEL_STAGE4 = 4'd5,
    SEL_STAGE5 = 4'd6,
    SEL_STAGE6 = 4'd7,
    SEL_STAGE7 = 4'd8
  } sel_e;

  function automatic sel_e stage_sel(int unsigned k);
    return sel_e'(4'(k + 1));
  endfunction

endpackage

// File: rtl/forward_sb_if.sv
// Issue, load-return and read-port bundle of the forwarding scoreboard.
interface forward_sb_if #(
  parameter int unsigned NUM_RD = forward_sb_pkg::DEF_NUM_RD,
  parameter int unsigned DW     = forward_sb_pkg::DEF_DW,
  parameter int unsigned AW     = forward_sb_pkg::DEF_AW,
  parameter int unsigned CNT_W  = forward_sb_pkg::DEF_CNT_W
);
  logic                 hold;
  logic                 iss_valid;
  logic                 iss_we;
  logic [AW-1:0]        iss_addr;
  logic                 iss_is_load;
  logic [DW-1:0]        iss_data;
  logic                 ld_valid;
  logic [DW-1:0]        ld_data;
  logic [NUM_RD-1:0]    rd_en;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_rf_data;
  logic [NUM_RD*DW-1:0] fwd_data;
  logic [NUM_RD-1:0]    fwd_hit;
  logic                 stall;
  logic                 ld_err;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output hold, iss_valid, iss_we, iss_addr, iss_is_load, iss_data,
    output ld_valid, ld_data, rd_en, rd_addr, rd_rf_data,
    input  fwd_data, fwd_hit, stall, ld_err, stall_cnt
  );

  modport slave (
    input  hold, iss_valid, iss_we, iss_addr, iss_is_load, iss_data,
    input  ld_valid, ld_data, rd_en, rd_addr, rd_rf_data,
    output fwd_data, fwd_hit, stall, ld_err, stall_cnt
  );
endinterface

// File: rtl/forward_sb_port.sv
// One read port: picks the youngest in-flight write to its source register,
// else the register-file value, and flags a hazard on an unfilled load.
module forward_sb_port import forward_sb_pkg::*; #(
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter bit          ZERO_REG = DEF_ZERO_REG
) (
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_rf_data,
  input  logic          i_vld      [DEPTH],
  input  logic [AW-1:0] i_ent_addr [DEPTH],
  input  logic          i_ent_rdy  [DEPTH],
  input  logic [DW-1:0] i_ent_data [DEPTH],
  output logic [DW-1:0] o_data,
  output logic          o_hit,
  output logic          o_hazard
);
  localparam int unsigned IW = $clog2(DEPTH);

  sel_e          w_sel;
  logic [IW-1:0] w_idx;
  logic          w_zero;

  assign w_zero = ZERO_REG && (i_addr == AW'(ZERO_ADDR));

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    w_sel = SEL_ORI;
    w_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_vld[DEPTH-1-i] && (i_ent_addr[DEPTH-1-i] == i_addr) && !w_zero) begin
        w_sel = stage_sel(DEPTH - 1 - i);
        w_idx = IW'(DEPTH - 1 - i);
      end
    end
  end

  assign o_hit    = (w_sel != SEL_ORI);
  assign o_data   = o_hit ? i_ent_data[w_idx] : i_rf_data;
  assign o_hazard = i_en && o_hit && !i_ent_rdy[w_idx];

endmodule

// File: rtl/forward_sb.sv
// Forwarding scoreboard: DEPTH-stage shift register of in-flight writes,
// variable-latency load fill, NUM_RD forwarding ports and load-use stall.
module forward_sb import forward_sb_pkg::*; #(
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter bit          ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic          clk,
  input logic          rst,
  forward_sb_if.slave  sb
);
  localparam int unsigned IW = $clog2(DEPTH);

  logic          r_vld  [DEPTH];
  logic [AW-1:0] r_addr [DEPTH];
  logic          r_rdy  [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic          r_ld_err;
  logic [CNT_W-1:0] r_cnt;

  logic          w_rdy  [DEPTH];
  logic [DW-1:0] w_data [DEPTH];
  logic          w_fill_hit;
  logic [IW-1:0] w_fill_idx;
  logic          w_cap;
  logic [NUM_RD-1:0]    w_haz;
  logic [NUM_RD-1:0]    w_hit;
  logic [NUM_RD*DW-1:0] w_fwd;

  // Oldest waiting load: the highest valid stage still not ready.
  always_comb begin
    w_fill_hit = 1'b0;
    w_fill_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (r_vld[k] && !r_rdy[k]) begin
        w_fill_hit = 1'b1;
        w_fill_idx = IW'(k);
      end
    end
  end

  // Fill is applied before resolve so a returning load clears its hazard at once.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_rdy[k]  = r_rdy[k];
      w_data[k] = r_data[k];
      if (sb.ld_valid && w_fill_hit && (w_fill_idx == IW'(k))) begin
        w_rdy[k]  = 1'b1;
        w_data[k] = sb.ld_data;
      end
    end
  end

  assign w_cap = sb.iss_valid && sb.iss_we &&
                 !(ZERO_REG && (sb.iss_addr == AW'(ZERO_ADDR)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_vld[k]  <= 1'b0;
        r_addr[k] <= '0;
        r_rdy[k]  <= 1'b0;
        r_data[k] <= '0;
      end
      r_ld_err <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (!sb.hold) begin
        r_vld[0]  <= w_cap;
        r_addr[0] <= sb.iss_addr;
        r_rdy[0]  <= !sb.iss_is_load;
        r_data[0] <= sb.iss_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
          r_vld[k]  <= r_vld[k-1];
          r_addr[k] <= r_addr[k-1];
          r_rdy[k]  <= w_rdy[k-1];
          r_data[k] <= w_data[k-1];
        end
      end else begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          r_rdy[k]  <= w_rdy[k];
          r_data[k] <= w_data[k];
        end
      end
      if ((sb.ld_valid && !w_fill_hit) ||
          (!sb.hold && r_vld[DEPTH-1] && !w_rdy[DEPTH-1])) begin
        r_ld_err <= 1'b1;
      end
      if (sb.stall && !sb.hold && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    forward_sb_port #(
      .DW       (DW),
      .AW       (AW),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .i_en       (sb.rd_en[p]),
      .i_addr     (sb.rd_addr[p*AW +: AW]),
      .i_rf_data  (sb.rd_rf_data[p*DW +: DW]),
      .i_vld      (r_vld),
      .i_ent_addr (r_addr),
      .i_ent_rdy  (w_rdy),
      .i_ent_data (w_data),
      .o_data     (w_fwd[p*DW +: DW]),
      .o_hit      (w_hit[p]),
      .o_hazard   (w_haz[p])
    );
  end

  assign sb.fwd_data  = w_fwd;
  assign sb.fwd_hit   = w_hit;
  assign sb.stall     = |w_haz;
  assign sb.ld_err    = r_ld_err;
  assign sb.stall_cnt = r_cnt;

endmodule

// File: tb/tb_forward_sb.sv
// Directed table plus randomized run of forward_sb against a queue-based model.
module tb_forward_sb;
  localparam int D  = 3;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  forward_sb_if #(.NUM_RD(NR), .DW(32), .AW(5), .CNT_W(4)) sb ();

  forward_sb #(
    .NUM_RD(NR), .DW(32), .AW(5), .DEPTH(D), .ZERO_REG(1'b1), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  // ---------------- reference model: list of in-flight writes, youngest first
  typedef struct {
    bit          vld;
    logic [4:0]  addr;
    bit          rdy;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  ent_t        mv[$];
  bit          m_err;
  logic [3:0]  m_cnt;
  bit          m_hit [NR];
  bit          m_haz [NR];
  logic [31:0] m_dat [NR];
  bit          m_stall;
  bit          m_nofill;

  task automatic model_clear();
    ent_t e;
    e = '{vld: 1'b0, addr: 5'd0, rdy: 1'b0, data: 32'h0};
    mq.delete();
    for (int j = 0; j < D; j++) mq.push_back(e);
    m_err = 1'b0;
    m_cnt = 4'd0;
  endtask

  task automatic model_eval();
    int fi;
    ent_t e;
    logic [4:0] a;
    bit found;
    fi = -1;
    mv = mq;
    for (int j = 0; j < D; j++) if (mv[j].vld && !mv[j].rdy) fi = j;
    m_nofill = 1'b0;
    if (sb.ld_valid) begin
      if (fi < 0) m_nofill = 1'b1;
      else begin
        e = mv[fi];
        e.rdy = 1'b1;
        e.data = sb.ld_data;
        mv[fi] = e;
      end
    end
    m_stall = 1'b0;
    for (int p = 0; p < NR; p++) begin
      a = sb.rd_addr[p*5 +: 5];
      m_hit[p] = 1'b0;
      m_haz[p] = 1'b0;
      m_dat[p] = sb.rd_rf_data[p*32 +: 32];
      found = 1'b0;
      if (a != 5'd0) begin
        for (int j = 0; j < D; j++) begin
          if (!found && mv[j].vld && mv[j].addr == a) begin
            found = 1'b1;
            m_hit[p] = 1'b1;
            m_dat[p] = mv[j].data;
            m_haz[p] = sb.rd_en[p] && !mv[j].rdy;
          end
        end
      end
      if (m_haz[p]) m_stall = 1'b1;
    end
  endtask

  task automatic model_step();
    ent_t c;
    model_eval();
    if (rst) begin
      model_clear();
    end else begin
      if (m_nofill) m_err = 1'b1;
      if (!sb.hold) begin
        if (mv[D-1].vld && !mv[D-1].rdy) m_err = 1'b1;
        c.vld  = sb.iss_valid && sb.iss_we && (sb.iss_addr != 5'd0);
        c.addr = sb.iss_addr;
        c.rdy  = !sb.iss_is_load;
        c.data = sb.iss_data;
        void'(mv.pop_back());
        mv.push_front(c);
      end
      if (m_stall && !sb.hold && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      mq = mv;
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- directed table
  // ctl = {rst, hold, iss_valid(+we), iss_is_load, ld_valid}
  // ef  = {exp hit0, exp hit1, exp stall, skip data checks}
  typedef struct {
    logic [4:0]  ctl;
    logic [4:0]  ia;
    logic [31:0] idata;
    logic [31:0] ldat;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rf;
    logic [3:0]  ef;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [3:0]  ecnt;
    logic        eerr;
  } vec_t;

  vec_t vt[27];

  initial begin
    vt[0]  = '{5'b10000, 5'd0,  32'h0,  32'h0,    5'd0, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd0, 1'b0};
    vt[1]  = '{5'b00100, 5'd3,  32'h11, 32'h0,    5'd3, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd0, 1'b0};
    vt[2]  = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd3, 5'd0,  32'h0,    4'b1000, 32'h11,   32'h0,    4'd0, 1'b0};
    vt[3]  = '{5'b00100, 5'd5,  32'hA,  32'h0,    5'd5, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd0, 1'b0};
    vt[4]  = '{5'b00100, 5'd5,  32'hB,  32'h0,    5'd5, 5'd0,  32'h0,    4'b1000, 32'hA,    32'h0,    4'd0, 1'b0};
    vt[5]  = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd5, 5'd0,  32'h0,    4'b1000, 32'hB,    32'h0,    4'd0, 1'b0};
    vt[6]  = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd5, 5'd0,  32'h0,    4'b1000, 32'hB,    32'h0,    4'd0, 1'b0};
    vt[7]  = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd5, 5'd0,  32'h0,    4'b1000, 32'hB,    32'h0,    4'd0, 1'b0};
    vt[8]  = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd5, 5'd0,  32'h1234, 4'b0000, 32'h1234, 32'h1234, 4'd0, 1'b0};
    vt[9]  = '{5'b00110, 5'd7,  32'h0,  32'h0,    5'd1, 5'd7,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd0, 1'b0};
    vt[10] = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd1, 5'd7,  32'h0,    4'b0111, 32'h0,    32'h0,    4'd0, 1'b0};
    vt[11] = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd1, 5'd7,  32'h0,    4'b0111, 32'h0,    32'h0,    4'd1, 1'b0};
    vt[12] = '{5'b00001, 5'd0,  32'h0,  32'hDEAD, 5'd1, 5'd7,  32'h0,    4'b0100, 32'h0,    32'hDEAD, 4'd2, 1'b0};
    vt[13] = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd1, 5'd7,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd2, 1'b0};
    vt[14] = '{5'b00100, 5'd2,  32'h5,  32'h0,    5'd2, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd2, 1'b0};
    vt[15] = '{5'b01100, 5'd2,  32'h77, 32'h0,    5'd2, 5'd0,  32'h0,    4'b1000, 32'h5,    32'h0,    4'd2, 1'b0};
    vt[16] = '{5'b01100, 5'd2,  32'h77, 32'h0,    5'd2, 5'd0,  32'h0,    4'b1000, 32'h5,    32'h0,    4'd2, 1'b0};
    vt[17] = '{5'b01100, 5'd2,  32'h77, 32'h0,    5'd2, 5'd0,  32'h0,    4'b1000, 32'h5,    32'h0,    4'd2, 1'b0};
    vt[18] = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd2, 5'd0,  32'h0,    4'b1000, 32'h5,    32'h0,    4'd2, 1'b0};
    vt[19] = '{5'b00100, 5'd0,  32'hFF, 32'h0,    5'd0, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd2, 1'b0};
    vt[20] = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd0, 5'd0,  32'h1234, 4'b0000, 32'h1234, 32'h1234, 4'd2, 1'b0};
    vt[21] = '{5'b00001, 5'd0,  32'h0,  32'h0,    5'd0, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd2, 1'b0};
    vt[22] = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd0, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd2, 1'b1};
    vt[23] = '{5'b00110, 5'd9,  32'h0,  32'h0,    5'd9, 5'd0,  32'h0,    4'b0000, 32'h0,    32'h0,    4'd2, 1'b1};
    vt[24] = '{5'b00110, 5'd10, 32'h0,  32'h0,    5'd9, 5'd0,  32'h0,    4'b1011, 32'h0,    32'h0,    4'd2, 1'b1};
    vt[25] = '{5'b10000, 5'd0,  32'h0,  32'h0,    5'd9, 5'd10, 32'h0,    4'b1111, 32'h0,    32'h0,    4'd3, 1'b1};
    vt[26] = '{5'b00000, 5'd0,  32'h0,  32'h0,    5'd9, 5'd10, 32'h0,    4'b0000, 32'h0,    32'h0,    4'd0, 1'b0};
  end

  task automatic drive_idle();
    sb.hold = 1'b0; sb.iss_valid = 1'b0; sb.iss_we = 1'b0; sb.iss_addr = '0;
    sb.iss_is_load = 1'b0; sb.iss_data = '0; sb.ld_valid = 1'b0; sb.ld_data = '0;
    sb.rd_en = '0; sb.rd_addr = '0; sb.rd_rf_data = '0;
  endtask

  initial begin
    logic [31:0] rfv;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    for (int i = 0; i < 27; i++) begin
      rst            = vt[i].ctl[4];
      sb.hold        = vt[i].ctl[3];
      sb.iss_valid   = vt[i].ctl[2];
      sb.iss_we      = vt[i].ctl[2];
      sb.iss_is_load = vt[i].ctl[1];
      sb.ld_valid    = vt[i].ctl[0];
      sb.iss_addr    = vt[i].ia;
      sb.iss_data    = vt[i].idata;
      sb.ld_data     = vt[i].ldat;
      sb.rd_en       = 3'b011;
      sb.rd_addr     = {5'd0, vt[i].ra1, vt[i].ra0};
      rfv            = vt[i].rf;
      sb.rd_rf_data  = {rfv, rfv, rfv};
      #1;
      chk($sformatf("v%0d_hit0", i), 64'(sb.fwd_hit[0]), 64'(vt[i].ef[3]));
      chk($sformatf("v%0d_hit1", i), 64'(sb.fwd_hit[1]), 64'(vt[i].ef[2]));
      chk($sformatf("v%0d_stall", i), 64'(sb.stall), 64'(vt[i].ef[1]));
      if (!vt[i].ef[0]) begin
        chk($sformatf("v%0d_data0", i), 64'(sb.fwd_data[31:0]), 64'(vt[i].ed0));
        chk($sformatf("v%0d_data1", i), 64'(sb.fwd_data[63:32]), 64'(vt[i].ed1));
      end
      chk($sformatf("v%0d_cnt", i), 64'(sb.stall_cnt), 64'(vt[i].ecnt));
      chk($sformatf("v%0d_err", i), 64'(sb.ld_err), 64'(vt[i].eerr));
      tick();
    end

    for (int n = 0; n < 2000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      sb.hold        = ($urandom_range(0, 5) == 0);
      sb.iss_valid   = 1'($urandom_range(0, 1));
      sb.iss_we      = ($urandom_range(0, 3) != 0);
      sb.iss_is_load = ($urandom_range(0, 2) == 0);
      sb.iss_addr    = 5'($urandom_range(0, 7));
      sb.iss_data    = $urandom;
      sb.ld_valid    = ($urandom_range(0, 4) == 0);
      sb.ld_data     = $urandom;
      sb.rd_en       = 3'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++) begin
        sb.rd_addr[p*5 +: 5]     = 5'($urandom_range(0, 7));
        sb.rd_rf_data[p*32 +: 32] = $urandom;
      end
      #1;
      model_eval();
      for (int p = 0; p < NR; p++) begin
        if (sb.rd_en[p]) begin
          chk($sformatf("r%0d_hit%0d", n, p), 64'(sb.fwd_hit[p]), 64'(m_hit[p]));
          if (!m_haz[p])
            chk($sformatf("r%0d_data%0d", n, p), 64'(sb.fwd_data[p*32 +: 32]), 64'(m_dat[p]));
        end
      end
      chk($sformatf("r%0d_stall", n), 64'(sb.stall), 64'(m_stall));
      chk($sformatf("r%0d_cnt", n), 64'(sb.stall_cnt), 64'(m_cnt));
      chk($sformatf("r%0d_err", n), 64'(sb.ld_err), 64'(m_err));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
